hdmi_audio_fifo: RTL and testbench

// - Upstream feeder for the HDMI data-island encoder: buffers 32-bit stereo PCM words written by the host
//   (audio_w/audio) and hands one L/R pair per audio-sample packet slot (rd strobe, 2 per scanline).
// - Owns the IEC 60958 frame counter (csb, 0..191) so the encoder sends channel-status bits and the B flag.
// - Sends silence instead of stale data on underflow. Re-primes to a low-water mark before resuming.
//

---
 rtl/hdmi_audio_pkg.sv | 6 +
 rtl/audio_sample_ram.sv | 21 ++
 rtl/hdmi_audio_fifo.sv | 68 ++++++
 tb/tb_hdmi_audio_fifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hdmi_audio_pkg.sv
// hdmi_audio_pkg: shared types and constants for the HDMI audio sample FIFO
package hdmi_audio_pkg;
  localparam int CSB_FRAME = 192;
  typedef struct packed {logic [15:0] r, l;} stereo_t;
  typedef enum logic {PRIME, RUN} afifo_state_t;
endpackage

// File: rtl/audio_sample_ram.sv
// audio_sample_ram: DEPTH x 32 simple dual-port RAM with registered read, no reset
module audio_sample_ram
  import hdmi_audio_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  stereo_t       wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output stereo_t       rdata
);
  stereo_t mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/hdmi_audio_fifo.sv
// hdmi_audio_fifo: PCM sample buffer with low-water priming, silence on underflow and IEC 60958 frame count
module hdmi_audio_fifo
  import hdmi_audio_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int AW        = 6,
  parameter int LOW_WATER = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          audio_w,
  input  logic [31:0]   audio,
  input  logic          rd,
  output logic [15:0]   lsample,
  output logic [15:0]   rsample,
  output logic [7:0]    csb,
  output logic          frame_b,
  output logic [AW:0]   level,
  output logic          streaming,
  output logic          underflow,
  output logic          overflow,
  input  logic          clr_flags
);
  logic [AW-1:0] wptr, rptr;
  afifo_state_t state;
  stereo_t q;
  logic popped, pop, wr_ok, under_ev;
  assign pop      = rd && state == RUN && level != '0;
  assign under_ev = rd && state == RUN && level == '0;
  assign wr_ok    = audio_w && (level < (AW+1)'(DEPTH) || pop);
  audio_sample_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (stereo_t'(audio)),
    .re    (pop),
    .raddr (rptr),
    .rdata (q)
  );
  // RAM output has no reset; popped gates it so reset and silent reads show zero
  assign {rsample, lsample} = popped ? q : '0;
  assign frame_b   = csb == '0;
  assign streaming = state == RUN;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      state     <= PRIME;
      popped    <= 1'b0;
      csb       <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      level <= level + (AW+1)'(wr_ok) - (AW+1)'(pop);
      if (rd) begin
        popped <= pop;
        csb    <= csb == 8'(CSB_FRAME - 1) ? '0 : csb + 8'd1;
      end
      underflow <= under_ev | (underflow & ~clr_flags);
      overflow  <= (audio_w & ~wr_ok) | (overflow & ~clr_flags);
      state     <= state == PRIME ? (level >= (AW+1)'(LOW_WATER) ? RUN : PRIME)
                                  : (under_ev ? PRIME : RUN);
    end
  end
endmodule

// File: tb/tb_hdmi_audio_fifo.sv
// tb_hdmi_audio_fifo: directed self-checking bench for hdmi_audio_fifo
module tb_hdmi_audio_fifo;
  logic        clk = 1'b0, rst_n = 1'b0, audio_w = 1'b0, rd = 1'b0, clr_flags = 1'b0;
  logic [31:0] audio = '0;
  logic [15:0] lsample, rsample;
  logic [7:0]  csb, ecsb;
  logic        frame_b, streaming, underflow, overflow;
  logic [6:0]  level;
  int nvec = 0, nerr = 0, wi = 0, ri = 0;

  hdmi_audio_fifo dut (
    .clk(clk), .rst_n(rst_n), .audio_w(audio_w), .audio(audio), .rd(rd),
    .lsample(lsample), .rsample(rsample), .csb(csb), .frame_b(frame_b),
    .level(level), .streaming(streaming), .underflow(underflow),
    .overflow(overflow), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int i);
    return {16'(16'h8000 + i), 16'(16'h0100 + i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bump_csb();
    ecsb = (ecsb == 8'd191) ? 8'd0 : ecsb + 8'd1;
  endtask

  initial begin
    ecsb = 8'd0;
    #12;
    chk("rst_samples", {rsample, lsample}, 32'd0);
    chk("rst_csb", 32'(csb), 32'd0);
    chk("rst_frame_b", 32'(frame_b), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_flags", {29'd0, streaming, underflow, overflow}, 32'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1;
      tick();
      rd = 1'b0;
      bump_csb();
      chk("prime_silence", {rsample, lsample}, 32'd0);
      chk("prime_csb", 32'(csb), 32'(ecsb));
      chk("prime_flags", {30'd0, streaming, underflow}, 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      audio_w = 1'b1;
      audio = word(wi);
      tick();
      wi++;
    end
    audio_w = 1'b0;
    chk("fill16_level", 32'(level), 32'd16);
    tick();
    chk("fill16_streaming", 32'(streaming), 32'd1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    bump_csb();
    chk("first_pop", {rsample, lsample}, 32'h8000_0100);
    chk("first_level", 32'(level), 32'd15);
    ri = 1;
    tick();
    chk("hold_sample", {rsample, lsample}, 32'h8000_0100);
    chk("hold_csb", 32'(csb), 32'(ecsb));
    for (int n = 0; n < 200; n++) begin
      audio_w = 1'b1;
      audio = word(wi);
      rd = 1'b1;
      tick();
      wi++;
      bump_csb();
      chk("stream_sample", {rsample, lsample}, word(ri));
      chk("stream_csb", 32'(csb), 32'(ecsb));
      chk("stream_frame_b", 32'(frame_b), 32'(ecsb == 8'd0));
      ri++;
    end
    audio_w = 1'b0;
    chk("stream_level", 32'(level), 32'd15);
    for (int n = 0; n < 15; n++) begin
      rd = 1'b1;
      tick();
      bump_csb();
      chk("drain_sample", {rsample, lsample}, word(ri));
      ri++;
    end
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_streaming", 32'(streaming), 32'd1);
    tick();
    rd = 1'b0;
    bump_csb();
    chk("under_silence", {rsample, lsample}, 32'd0);
    chk("under_flags", {30'd0, streaming, underflow}, 32'd1);
    chk("under_csb", 32'(csb), 32'(ecsb));
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("clr_underflow", 32'(underflow), 32'd0);
    for (int i = 0; i < 64; i++) begin
      audio_w = 1'b1;
      audio = word(wi);
      tick();
      wi++;
    end
    chk("full_level", 32'(level), 32'd64);
    chk("full_streaming", 32'(streaming), 32'd1);
    audio = word(wi);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    wi++;
    bump_csb();
    chk("full_wr_pop_level", 32'(level), 32'd64);
    chk("full_wr_pop_ovf", 32'(overflow), 32'd0);
    chk("full_wr_pop_sample", {rsample, lsample}, word(ri));
    ri++;
    audio = 32'hdead_beef;
    tick();
    audio_w = 1'b0;
    chk("drop_overflow", 32'(overflow), 32'd1);
    chk("drop_level", 32'(level), 32'd64);
    clr_flags = 1'b1;
    tick();
    chk("clr_overflow", 32'(overflow), 32'd0);
    audio_w = 1'b1;
    tick();
    audio_w = 1'b0;
    clr_flags = 1'b0;
    chk("clr_vs_event", 32'(overflow), 32'd1);
    for (int n = 0; n < 64; n++) begin
      rd = 1'b1;
      tick();
      bump_csb();
      chk("full_drain_sample", {rsample, lsample}, word(ri));
      ri++;
    end
    rd = 1'b0;
    chk("full_drain_level", 32'(level), 32'd0);
    for (int i = 0; i < 20; i++) begin
      audio_w = 1'b1;
      audio = word(wi);
      tick();
      wi++;
    end
    audio_w = 1'b0;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("pre_reset_sample", {rsample, lsample}, word(ri));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_samples", {rsample, lsample}, 32'd0);
    chk("async_rst_level", 32'(level), 32'd0);
    chk("async_rst_csb", 32'(csb), 32'd0);
    chk("async_rst_flags", {28'd0, frame_b, streaming, underflow, overflow}, 32'd8);
    #4;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      audio_w = 1'b1;
      audio = word(500 + i);
      tick();
    end
    audio_w = 1'b0;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("reprime_silence", {rsample, lsample}, 32'd0);
    chk("reprime_level", 32'(level), 32'd5);
    chk("reprime_flags", {30'd0, streaming, underflow}, 32'd0);
    chk("reprime_csb", 32'(csb), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
